// File: rtl/sd_cmd_ctrl.sv
// rtl/sd_cmd_ctrl.sv - SD CMD line sequencer: sd_clk divider, CRC7 command frame, response capture
// Define SD_CMD_LONG_RESP_EN to support 136-bit R2 responses (resp_type 2).
module sd_cmd_ctrl #(
  parameter int CLK_DIV      = 125,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         clk_free,
  output logic         busy,
  output logic         done,
  output logic         resp_timeout,
  output logic         resp_err,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic         sd_clk,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_dir
);
`ifdef SD_CMD_LONG_RESP_EN
  localparam int RXW = 136;
`else
  localparam int RXW = 48;
`endif
  localparam logic [9:0]  DIV_TC = 10'(CLK_DIV - 1);
  localparam logic [15:0] TMO    = 16'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_CHECK, S_TRAIL, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     div_q, div_d;
  logic           sd_clk_q, sd_clk_d;
  logic           cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
  logic [47:0]    tx_q, tx_d;
  logic [RXW-1:0] rx_q, rx_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [1:0]     rtype_q, rtype_d;
  logic           tmo_q, tmo_d, err_q, err_d;
  logic [5:0]     idx_q, idx_d;
  logic [127:0]   data_q, data_d;
  logic           running, term, rise, fall;
  logic [15:0]    rlen;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int k = 39; k >= 0; k--) begin
      fb = d[k] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // sd_clk only runs during a transaction or when free-running is requested
  always_comb begin
    running  = ((state_q != S_IDLE) && (state_q != S_DONE)) || clk_free;
    term     = (div_q == DIV_TC);
    rise     = running && term && !sd_clk_q;
    fall     = running && term && sd_clk_q;
    div_d    = (!running || term) ? 10'd0 : div_q + 10'd1;
    sd_clk_d = !running ? 1'b0 : (term ? ~sd_clk_q : sd_clk_q);
    rlen     = (rtype_q == 2'd2) ? 16'd136 : 16'd48;
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    cmd_o_d  = cmd_o_q;
    cmd_oe_d = cmd_oe_q;
    rtype_d  = rtype_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    idx_d    = idx_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        cmd_o_d  = 1'b1;
        cmd_oe_d = 1'b0;
        if (cmd_start) begin
          tx_d    = {2'b01, cmd_index, cmd_arg, crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
          rx_d    = '0;
          cnt_d   = '0;
          rtype_d = resp_type;
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          data_d  = '0;
          state_d = S_SEND;
`ifndef SD_CMD_LONG_RESP_EN
          if (resp_type == 2'd2) state_d = S_CHECK;
`endif
        end
      end
      S_SEND: begin
        if (fall) begin
          if (cnt_q == 16'd48) begin
            cmd_o_d  = 1'b1;
            cmd_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_TURN;
          end else begin
            cmd_o_d  = tx_q[47];
            cmd_oe_d = 1'b1;
            tx_d     = {tx_q[46:0], 1'b1};
            cnt_d    = cnt_q + 16'd1;
          end
        end
      end
      S_TURN: begin
        if (fall) begin
          if (cnt_q == 16'd1) begin
            cnt_d   = '0;
            state_d = (rtype_q == 2'd0) ? S_TRAIL : S_WAIT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!sd_cmd_i) begin
            rx_d    = {rx_q[RXW-2:0], 1'b0};
            cnt_d   = 16'd1;
            state_d = S_RECV;
          end else if (cnt_q + 16'd1 == TMO) begin
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_TRAIL;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RECV: begin
        if (rise) begin
          rx_d  = {rx_q[RXW-2:0], sd_cmd_i};
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == rlen) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = S_TRAIL;
        if (rtype_q == 2'd2) begin
`ifdef SD_CMD_LONG_RESP_EN
          err_d  = rx_q[135] | rx_q[134] | ~rx_q[0];
          data_d = rx_q[127:0];
`else
          err_d   = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          err_d  = rx_q[47] | rx_q[46] | ~rx_q[0] |
                   ((rtype_q == 2'd1) && (rx_q[7:1] != crc7(rx_q[47:8])));
          idx_d  = rx_q[45:40];
          data_d = {96'd0, rx_q[39:8]};
        end
      end
      S_TRAIL: begin
        // N_CC: eight full sd_clk periods, finishing on a falling edge
        if (rise) cnt_d = cnt_q + 16'd1;
        else if (fall && cnt_q == 16'd8) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SD_CMD_LONG_RESP_EN
  logic [5:0] rx_unused;
  assign rx_unused = rx_q[133:128];
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      sd_clk_q <= 1'b0;
      cmd_o_q  <= 1'b1;
      cmd_oe_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      rtype_q  <= '0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sd_clk_q <= sd_clk_d;
      cmd_o_q  <= cmd_o_d;
      cmd_oe_q <= cmd_oe_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      rtype_q  <= rtype_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign resp_timeout = tmo_q;
  assign resp_err     = err_q;
  assign resp_index   = idx_q;
  assign resp_data    = data_q;
  assign sd_clk       = sd_clk_q;
  assign sd_cmd_o     = cmd_o_q;
  assign sd_cmd_oe    = cmd_oe_q;
  assign sd_cmd_dir   = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb/tb_sd_cmd_ctrl.sv - directed bench for sd_cmd_ctrl with a simple SD card response model
module tb_sd_cmd_ctrl;
  logic         clk = 1'b0;
  logic         reset_reset = 1'b1;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         clk_free = 1'b0;
  logic         busy, done, resp_timeout, resp_err;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic         sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_dir;
  logic         sd_cmd_i = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  bit dir_bad = 0;

  always #5 clk = ~clk;

  sd_cmd_ctrl #(.CLK_DIV(2), .RESP_TIMEOUT(64)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .cmd_start(cmd_start),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .clk_free(clk_free), .busy(busy), .done(done), .resp_timeout(resp_timeout),
    .resp_err(resp_err), .resp_index(resp_index), .resp_data(resp_data),
    .sd_clk(sd_clk), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe),
    .sd_cmd_i(sd_cmd_i), .sd_cmd_dir(sd_cmd_dir)
  );

  // Issues one command, captures the driven frame, and plays the card reply.
  // rises counts sd_clk rising edges from the release of CMD until done.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int reply_after, input logic [135:0] reply, input int reply_len,
                         input int dup_at,
                         output logic [47:0] frame, output int nbits, output int rises,
                         output bit got_done, output int done_cyc, output bit busy0,
                         output bit oe_seen);
    int   phase;
    int   sent;
    logic prev_clk, prev_oe;
    frame = '0; nbits = 0; rises = 0; got_done = 0; done_cyc = -1; oe_seen = 0;
    phase = 0; sent = 0;
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = rt; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    busy0 = busy;
    prev_clk = sd_clk; prev_oe = sd_cmd_oe;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == dup_at) begin
        cmd_index = 6'd8; cmd_arg = 32'hFFFF_FFFF; resp_type = 2'd1; cmd_start = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
      if (sd_cmd_oe !== sd_cmd_dir) dir_bad = 1;
      if (sd_cmd_oe) oe_seen = 1;
      if (phase == 0 && prev_oe && !sd_cmd_oe) phase = 1;
      if (sd_clk && !prev_clk) begin
        if (sd_cmd_oe) begin
          frame = {frame[46:0], sd_cmd_o};
          nbits++;
        end
        if (phase == 1) rises++;
      end
      if (!sd_clk && prev_clk && phase == 1) begin
        if (reply_len > 0 && rises >= reply_after && sent < reply_len) begin
          sd_cmd_i = reply[reply_len-1-sent];
          sent++;
        end else begin
          sd_cmd_i = 1'b1;
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      prev_clk = sd_clk; prev_oe = sd_cmd_oe;
    end
    cmd_start = 1'b0;
    sd_cmd_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done, resp_timeout, resp_err} !== 8'b0100_0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=01000000",
               {sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done, resp_timeout, resp_err});
    end
    vectors++;
    if (resp_index !== 6'd0 || resp_data !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_resp got idx=%h data=%h want 0", resp_index, resp_data);
    end
    reset_reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (sd_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_clk_stopped got=%b want=0", sd_clk);
    end
  endtask

  task automatic test_cmd0();
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    run_cmd(6'd0, 32'h0, 2'd0, 0, 136'd0, 0, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (b0 !== 1'b1) begin miscompares++; $display("FAIL cmd0_busy_rise got=%b want=1", b0); end
    vectors++;
    if (nb != 48 || fr !== 48'h400000000095) begin
      miscompares++; $display("FAIL cmd0_frame got=%h bits=%0d want=400000000095 bits=48", fr, nb);
    end
    vectors++;
    if (!gd || rs != 10) begin
      miscompares++; $display("FAIL cmd0_done got done=%0d rises=%0d want done=1 rises=10", gd, rs);
    end
    vectors++;
    if (busy !== 1'b0 || resp_timeout !== 1'b0 || resp_err !== 1'b0) begin
      miscompares++; $display("FAIL cmd0_status got busy=%b tmo=%b err=%b want 0 0 0", busy, resp_timeout, resp_err);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL cmd0_done_width got=%b want=0", done); end
  endtask

  task automatic test_cmd8(input logic [7:0] crc_byte, input bit want_err);
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    logic [135:0] rep;
    rep = {88'd0, 40'h08000001AA, crc_byte};
    run_cmd(6'd8, 32'h000001AA, 2'd1, 5, rep, 48, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (nb != 48 || fr !== 48'h48000001AA87) begin
      miscompares++; $display("FAIL cmd8_frame got=%h bits=%0d want=48000001AA87 bits=48", fr, nb);
    end
    vectors++;
    if (!gd || rs != 61) begin
      miscompares++; $display("FAIL cmd8_done got done=%0d rises=%0d want done=1 rises=61", gd, rs);
    end
    vectors++;
    if (resp_index !== 6'd8 || resp_data !== 128'h1AA) begin
      miscompares++; $display("FAIL cmd8_resp got idx=%h data=%h want idx=08 data=1aa", resp_index, resp_data);
    end
    vectors++;
    if (resp_err !== want_err || resp_timeout !== 1'b0) begin
      miscompares++; $display("FAIL cmd8_err got err=%b tmo=%b want err=%b tmo=0", resp_err, resp_timeout, want_err);
    end
  endtask

  task automatic test_timeout();
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    run_cmd(6'd55, 32'h0, 2'd1, 0, 136'd0, 0, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (fr !== 48'h770000000065) begin
      miscompares++; $display("FAIL cmd55_frame got=%h want=770000000065", fr);
    end
    vectors++;
    if (!gd || rs != 74) begin
      miscompares++; $display("FAIL timeout_rises got done=%0d rises=%0d want done=1 rises=74", gd, rs);
    end
    vectors++;
    if (resp_timeout !== 1'b1 || resp_err !== 1'b0 || resp_data !== 128'd0) begin
      miscompares++; $display("FAIL timeout_status got tmo=%b err=%b data=%h want tmo=1 err=0 data=0",
                              resp_timeout, resp_err, resp_data);
    end
  endtask

  task automatic test_long_resp();
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    logic [127:0] cid;
    logic [135:0] rep;
    cid = 128'h1D4144534420202010A0B1C2D300E5AB;
    rep = {2'b00, 6'b111111, cid};
`ifdef SD_CMD_LONG_RESP_EN
    run_cmd(6'd2, 32'h0, 2'd2, 5, rep, 136, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (fr !== 48'h42000000004D) begin
      miscompares++; $display("FAIL cmd2_frame got=%h want=42000000004d", fr);
    end
    vectors++;
    if (!gd || resp_data !== cid || resp_err !== 1'b0) begin
      miscompares++; $display("FAIL cmd2_cid got done=%0d data=%h err=%b want data=%h err=0", gd, resp_data, resp_err, cid);
    end
`else
    run_cmd(6'd2, 32'h0, 2'd2, 5, rep, 136, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (!gd || dc != 0 || b0 !== 1'b1) begin
      miscompares++; $display("FAIL cmd2_reject_timing got done=%0d cyc=%0d busy=%b want done=1 cyc=0 busy=1", gd, dc, b0);
    end
    vectors++;
    if (oes || resp_err !== 1'b1 || resp_timeout !== 1'b0) begin
      miscompares++; $display("FAIL cmd2_reject got oe_seen=%0d err=%b tmo=%b want oe_seen=0 err=1 tmo=0", oes, resp_err, resp_timeout);
    end
`endif
  endtask

  task automatic test_clk_free();
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    int   toggles;
    bit   oe_idle;
    logic prev;
    clk_free = 1'b1;
    toggles = 0; oe_idle = 0;
    @(negedge clk);
    prev = sd_clk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sd_clk !== prev) toggles++;
      if (sd_cmd_oe) oe_idle = 1;
      prev = sd_clk;
    end
    vectors++;
    if (toggles != 10 || oe_idle) begin
      miscompares++; $display("FAIL clk_free_idle got toggles=%0d oe=%0d want toggles=10 oe=0", toggles, oe_idle);
    end
    run_cmd(6'd0, 32'h0, 2'd0, 0, 136'd0, 0, -1, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (fr !== 48'h400000000095 || nb != 48 || !gd || rs != 10) begin
      miscompares++; $display("FAIL clk_free_cmd0 got frame=%h bits=%0d done=%0d rises=%0d want 400000000095 48 1 10",
                              fr, nb, gd, rs);
    end
    clk_free = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [47:0] fr; int nb, rs, dc; bit gd, b0, oes;
    int  sent_bits;
    bit  done_seen;
    logic prev;
    @(negedge clk);
    cmd_index = 6'd0; cmd_arg = 32'h0; resp_type = 2'd0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    sent_bits = 0;
    prev = sd_clk;
    for (int i = 0; i < 2000 && sent_bits < 10; i++) begin
      @(negedge clk);
      if (sd_clk && !prev && sd_cmd_oe) sent_bits++;
      prev = sd_clk;
    end
    vectors++;
    if (sent_bits != 10) begin
      miscompares++; $display("FAIL mid_send_reach got bits=%0d want=10", sent_bits);
    end
    reset_reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done} !== 6'b010000) begin
      miscompares++; $display("FAIL mid_reset got=%b want=010000",
                              {sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done});
    end
    reset_reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    vectors++;
    if (done_seen) begin
      miscompares++; $display("FAIL mid_reset_quiet got done_or_busy=1 want=0");
    end
    run_cmd(6'd0, 32'h0, 2'd0, 0, 136'd0, 0, 20, fr, nb, rs, gd, dc, b0, oes);
    vectors++;
    if (fr !== 48'h400000000095 || nb != 48 || !gd || rs != 10) begin
      miscompares++; $display("FAIL ignore_start got frame=%h bits=%0d done=%0d rises=%0d want 400000000095 48 1 10",
                              fr, nb, gd, rs);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL ignore_start_idle got busy=%b want=0", busy);
    end
    test_cmd8(8'h13, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8(8'h13, 1'b0);
    test_cmd8(8'h15, 1'b1);
    test_timeout();
    test_long_resp();
    test_clk_free();
    test_back_to_back();
    vectors++;
    if (dir_bad) begin
      miscompares++; $display("FAIL dir_follows_oe got mismatch=1 want=0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sd_cmd_ctrl.md
# sd_cmd_ctrl

Hardware sequencer for the SD card CMD line, replacing bit-banged PIO control of sd_clk/sd_cmd/sd_cmd_dir. It generates the SD clock and serialises one 48-bit command frame with CRC7. It then turns the line around, waits for and deserialises the 48- or 136-bit response, checks it, and reports status to the Avalon-side register wrapper. The CMD line is split into o/oe/i; the top level builds the inout pad.

## Interface
Parameters:
- CLK_DIV, 125: clk_clk cycles per sd_clk half-period (50 MHz → 200 kHz); legal 1..1023.
- RESP_TIMEOUT, 64: max sd_clk rising edges after turnaround before a response start bit (N_CR).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- cmd_start  in  1  one-cycle request; accepted only when busy=0
- cmd_index  in  6  command index
- cmd_arg  in  32  command argument
- resp_type  in  2  0 none, 1 48-bit with CRC (R1/R6/R7), 2 136-bit (R2), 3 48-bit no CRC (R3)
- clk_free  in  1  1: sd_clk toggles continuously while idle (init 74 clocks)
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- resp_timeout  out  1  no start bit within RESP_TIMEOUT; valid with done, held until next accept
- resp_err  out  1  CRC, transmission-bit or end-bit error; valid with done, held
- resp_index  out  6  response bits [45:40] (48-bit types)
- resp_data  out  128  48-bit: [31:0]=bits[39:8], upper zero; R2: bits[127:0]
- sd_clk  out  1  SD clock
- sd_cmd_o  out  1  CMD drive value
- sd_cmd_oe  out  1  CMD output enable
- sd_cmd_i  in  1  CMD pad input, already 2-flop synchronised at top
- sd_cmd_dir  out  1  level-shifter direction, equals sd_cmd_oe

## Operation
- Divider counts 0..CLK_DIV-1; terminal count toggles sd_clk when running, producing strobes rise/fall for that clk_clk cycle. Running = busy or clk_free.
- Host updates sd_cmd_o on fall strobes; samples sd_cmd_i on rise strobes.
- FSM states:
  - IDLE: oe=0, o=1. On cmd_start, latch inputs, set busy, clear status, go SEND.
  - SEND: 48 bits MSB-first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1. oe=1 from first bit through end bit. CRC7 poly x^7+x^3+1, init 0, over first 40 bits.
  - TURN: oe=0 at the fall after the end bit, for 2 sd_clk periods. resp_type 0 → TRAIL.
  - WAIT: count rise strobes; sd_cmd_i=0 on a rise → RECV. Count reaching RESP_TIMEOUT → resp_timeout=1, TRAIL.
  - RECV: shift 47 (types 1/3) or 135 (type 2) more bits on rises, then CHECK.
  - CHECK: one clk_clk cycle. resp_err=1 if transmission bit≠0, end bit≠1, or (type 1) received CRC7 ≠ CRC7 over bits[47:8]. Type 2 has no outer CRC check. Load resp_index/resp_data.
  - TRAIL: 8 sd_clk periods (N_CC) with oe=0, then DONE.
  - DONE: pulse done, clear busy, IDLE.
- cmd_start while busy=1 is ignored; no queueing.
- resp outputs hold until next accepted cmd_start, which zeroes them.

## Timing
- Reset values: sd_clk=0, sd_cmd_o=1, sd_cmd_oe=0, sd_cmd_dir=0, busy=0, done=0, resp_timeout=0, resp_err=0, resp_index=0, resp_data=0; divider=0; FSM IDLE.
- Reset mid-transaction takes effect next edge: line released, sd_clk low, no done pulse.
- busy rises the cycle after the accepted cmd_start. The first bit (0) is driven at the first fall strobe after accept.
- Command frame: 48 sd_clk periods. The response start bit may arrive from the 2nd to the RESP_TIMEOUT-th rise after TURN.
- done is asserted exactly one cycle; busy falls in the same cycle as done.
- With clk_free=1 and idle, sd_clk toggles with oe=0; transaction start still aligns to the next fall strobe.
- CLK_DIV=1: sd_clk = clk_clk/2; all rules unchanged.

## Configuration
- SD_CMD_LONG_RESP_EN defined: resp_type 2 supported (136-bit shift register, 128-bit resp_data).
- Undefined: resp_data[127:32] tied 0, 48-bit shifter only. resp_type 2 is rejected: no frame is sent, done pulses 2 cycles after accept, resp_err=1, resp_timeout=0.

## Test plan
- CMD0, arg 0, type 0, CLK_DIV=2 → sd_cmd_o frame 0x400000000095 over 48 sd_clk, oe low after end bit, done after 8 trailing clocks, status 0.
- CMD8, arg 0x000001AA, type 1; model replies 0x08000001AA13 after 5 rises → frame 0x48000001AA87, resp_index=8, resp_data=0x1AA, resp_err=0.
- Same as previous, but the model corrupts CRC to 0x15 → resp_err=1, resp_data still 0x1AA.
- CMD55, type 1, no reply → resp_timeout=1 after exactly 64 rises in WAIT, done follows 8 trailing clocks.
- CMD2, type 2 with macro, 136-bit model CID → resp_data equals CID bits[127:0]. Without macro → resp_err=1, sd_cmd_oe never asserted.
- Assert reset_reset mid-SEND, then issue a second cmd_start during busy → outputs return to reset values next cycle; the second start is ignored, and a fresh start completes normally.
